fft_sdf_stage_ctrl: RTL and testbench
=====================================

Name: fft_sdf_stage_ctrl

Overview:
- Control and buffering shell for one radix-2 stage of the receiver FFT, with a single-path delay-feedback structure.
- Accepts a serial complex sample stream and holds the first half of each group in a delay buffer.
- Presents (xa, xb, w) pairs to an external pipelined butterfly and re-serialises the butterfly's ya/yb results into an output stream.
- Sits between consecutive butterfly instances; one instance per FFT stage.

Parameters:
- WIDTH, 16, bit width of each real/imag sample component (two's complement).
- LOG_N, 6, log2 of FFT size; twiddle address width is LOG_N-1.
- LOG_SPAN, 5, log2 of butterfly span HALF = 2^LOG_SPAN; legal range 0..LOG_N-1; group length = 2*HALF.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample strobe
- in_real, in_imag  in  WIDTH each  input sample
- tw_addr  out  LOG_N-1  twiddle ROM address (combinational)
- tw_real, tw_imag  in  WIDTH each  twiddle from ROM, same cycle as tw_addr
- bf_en  out  1  butterfly issue strobe (registered)
- bf_xa_real, bf_xa_imag, bf_xb_real, bf_xb_imag, bf_w_real, bf_w_imag  out  WIDTH each  butterfly operands (registered)
- bf_valid  in  1  butterfly result strobe (fixed 3-cycle latency after bf_en)
- bf_ya_real, bf_ya_imag, bf_yb_real, bf_yb_imag  in  WIDTH each  butterfly results
- out_valid  out  1  output sample strobe (registered)
- out_real, out_imag  out  WIDTH each  output sample

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high (rst). No backpressure anywhere; the stream is strobe-qualified only.
- In-counter k (LOG_SPAN bits) and phase bit ph count accepted samples (in_valid=1). k wraps at HALF-1 and toggles ph.
- ph=0 (fill):
  - Sample written to delay buffer D[k].
  - No butterfly issue.
- ph=1 (issue):
  - tw_addr = k << (LOG_N-1-LOG_SPAN), combinational from current k.
  - Next cycle: bf_en=1; bf_xa=D[k]; bf_xb=current sample; bf_w=tw.
  - bf_en=0 in any cycle with no ph=1 acceptance. Operand regs hold their last value when bf_en=0.
- Latency: in sample (ph=1) -> bf_en at +1 -> bf_valid at +4 -> out_valid at +5.
- Result path:
  - On bf_valid: ya is registered to out, and yb is pushed into FIFO Y (depth HALF).
  - A result counter r counts bf_valid pulses. When r wraps (HALF-th ya emitted), drain flag is set.
- Drain state:
  - While drain=1 and Y is non-empty, pop one yb per cycle to out, with out_valid=1.
  - Drain clears when Y becomes empty.
- Output order per group: ya[0..HALF-1] (gaps allowed if input had gaps), then yb[0..HALF-1] contiguous.
- Collision: bf_valid while drain=1 cannot occur. The next group's first result arrives at least HALF+1 cycles after the last ya. An implementation assertion flags it; ya has priority if it ever occurs (overflow-flag behaviour is undefined).
- Y overflow (push when full) cannot occur in legal use; same assertion.
- LOG_SPAN=0: D and Y hold one entry; k is constant 0; ph alternates every sample.
- Reset values:
  - bf_en=0, out_valid=0.
  - All data outputs 0, tw_addr=0.
  - k=0, ph=0, r=0, drain=0, Y empty.
  - Buffer contents are don't-care.
- Reset mid-group: all in-flight state is discarded. The first in_valid after reset is ph=0, k=0. Stale bf_valid pulses from the external pipeline are ignored for 3 cycles after rst deasserts.

Optional Feature:
- Macro FFT_STAGE_SCALE_EN.
- Defined: every output sample (ya and yb) is divided by 2 before registering: arithmetic shift right 1 with round-half-up (add 1, then shift, in WIDTH+1 bits, saturate to WIDTH). This prevents per-stage growth.
- Undefined: outputs pass through unmodified (WIDTH bits, wrap on overflow as delivered by the butterfly).

Test Plan:
- LOG_N=3, LOG_SPAN=0; tw=(256,0); inputs (256,0),(256,0) on consecutive cycles t,t+1 -> bf_en at t+2, out (512,0) at t+6, out (0,0) at t+7.
- LOG_N=6, LOG_SPAN=2; continuous inputs real=16*j, imag=0, j=0..7 -> tw_addr 0,8,16,24 during j=4..7; outputs 64,96,128,160 then -64,-64,-64,-64, eight consecutive out_valid cycles.
- Same config; in_valid low for 3 cycles between j=5 and j=6 -> ya outputs show a matching 3-cycle gap; yb drain starts only after the 4th ya.
- Same config; rst pulsed after j=5, then 8 fresh samples -> no output from the aborted group; the new group produces exactly 8 outputs in ya/yb order.
- FFT_STAGE_SCALE_EN defined, LOG_SPAN=0; inputs (3,-3),(0,0) with tw=(256,0) -> outputs (2,-1),(2,-1).
- Back-to-back 4 groups, LOG_SPAN=2 -> out_valid continuous after the first fill; collision/overflow assertions never fire.

Source files
------------

// File: rtl/fft_sdf_stage_ctrl.sv
// Control/buffering shell for one radix-2 single-path delay-feedback FFT stage.
// Define FFT_STAGE_SCALE_EN to halve every output sample (round-half-up, saturating).
module fft_sdf_stage_ctrl #(
    parameter int WIDTH    = 16,
    parameter int LOG_N    = 6,
    parameter int LOG_SPAN = 5
) (
    input  logic             clk,
    input  logic             rst,
    // All streams are strobe-qualified only: a sample/result moves in any cycle
    // whose valid/en strobe is high, and there is no backpressure on any path.
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic [LOG_N-2:0] tw_addr,
    input  logic [WIDTH-1:0] tw_real,
    input  logic [WIDTH-1:0] tw_imag,
    output logic             bf_en,
    output logic [WIDTH-1:0] bf_xa_real,
    output logic [WIDTH-1:0] bf_xa_imag,
    output logic [WIDTH-1:0] bf_xb_real,
    output logic [WIDTH-1:0] bf_xb_imag,
    output logic [WIDTH-1:0] bf_w_real,
    output logic [WIDTH-1:0] bf_w_imag,
    input  logic             bf_valid,
    input  logic [WIDTH-1:0] bf_ya_real,
    input  logic [WIDTH-1:0] bf_ya_imag,
    input  logic [WIDTH-1:0] bf_yb_real,
    input  logic [WIDTH-1:0] bf_yb_imag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag
);
    localparam int HALF     = 1 << LOG_SPAN;
    localparam int KW       = (LOG_SPAN > 0) ? LOG_SPAN : 1;
    localparam int AW       = LOG_N - 1;
    localparam int TW_SHIFT = LOG_N - 1 - LOG_SPAN;
    localparam int CW       = LOG_SPAN + 1;
    localparam logic [KW-1:0] K_LAST  = KW'(HALF - 1);
    localparam logic [CW-1:0] Y_DEPTH = CW'(HALF);

    function automatic logic [KW-1:0] wrap_inc(input logic [KW-1:0] v);
        return (v == K_LAST) ? '0 : v + KW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] x);
`ifdef FFT_STAGE_SCALE_EN
        logic signed [WIDTH:0] s;
        s = $signed({x[WIDTH-1], x}) + $signed((WIDTH+1)'(1));
        s = s >>> 1;
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
`else
        return x;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Input side: first half of each group fills D, second half issues.
    // ------------------------------------------------------------------
    logic [KW-1:0]        k;
    logic                 ph;
    logic [2*WIDTH-1:0]   d_mem [2**KW];

    assign tw_addr = AW'(k) << TW_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            ph         <= 1'b0;
            bf_en      <= 1'b0;
            bf_xa_real <= '0;
            bf_xa_imag <= '0;
            bf_xb_real <= '0;
            bf_xb_imag <= '0;
            bf_w_real  <= '0;
            bf_w_imag  <= '0;
        end else begin
            bf_en <= 1'b0;
            if (in_valid) begin
                k <= wrap_inc(k);
                if (k == K_LAST)
                    ph <= ~ph;
                if (ph) begin
                    bf_en                    <= 1'b1;
                    {bf_xa_real, bf_xa_imag} <= d_mem[k];
                    bf_xb_real               <= in_real;
                    bf_xb_imag               <= in_imag;
                    bf_w_real                <= tw_real;
                    bf_w_imag                <= tw_imag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid && !ph)
            d_mem[k] <= {in_real, in_imag};
    end

    // ------------------------------------------------------------------
    // Result side: ya goes straight out, yb is parked in Y and drained
    // contiguously once the group's last ya has been emitted.
    // ------------------------------------------------------------------
    logic [1:0]         ign_cnt;
    logic               bf_take;
    logic [KW-1:0]      r;
    logic [KW-1:0]      y_wr;
    logic [KW-1:0]      y_rd;
    logic [CW-1:0]      y_cnt;
    logic               drain;
    logic               y_empty;
    logic               y_full;
    logic [2*WIDTH-1:0] y_mem [2**KW];

    // Results still in the external pipeline when reset hit are dropped.
    assign bf_take = bf_valid && (ign_cnt == 2'd0);
    assign y_empty = (y_cnt == '0);
    assign y_full  = (y_cnt == Y_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            ign_cnt   <= 2'd3;
            r         <= '0;
            y_wr      <= '0;
            y_rd      <= '0;
            y_cnt     <= '0;
            drain     <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
        end else begin
            if (ign_cnt != 2'd0)
                ign_cnt <= ign_cnt - 2'd1;
            out_valid <= 1'b0;
            if (bf_take) begin
                out_valid <= 1'b1;
                out_real  <= scale(bf_ya_real);
                out_imag  <= scale(bf_ya_imag);
                r         <= wrap_inc(r);
                if (r == K_LAST)
                    drain <= 1'b1;
                if (!y_full) begin
                    y_wr  <= wrap_inc(y_wr);
                    y_cnt <= y_cnt + CW'(1);
                end
            end else if (drain) begin
                if (!y_empty) begin
                    out_valid              <= 1'b1;
                    {out_real, out_imag}   <= y_mem[y_rd];
                    y_rd                   <= wrap_inc(y_rd);
                    y_cnt                  <= y_cnt - CW'(1);
                end
                if (y_cnt <= CW'(1))
                    drain <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bf_take && !y_full)
            y_mem[y_wr] <= {scale(bf_yb_real), scale(bf_yb_imag)};
    end

    a_no_collision: assert property (@(posedge clk) disable iff (rst) !(bf_take && drain));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(bf_take && y_full));

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: a LOG_SPAN=2 instance against a group-level reference
// model with cycle-stamped expectations, plus a LOG_SPAN=0 instance for latency checks.
module tb_fft_sdf_stage_ctrl;
    localparam int W        = 16;
    localparam int LOG_N    = 6;
    localparam int LOG_SPAN = 2;
    localparam int HALF     = 1 << LOG_SPAN;
    localparam int AW       = LOG_N - 1;
    localparam int TW_SHIFT = LOG_N - 1 - LOG_SPAN;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A (LOG_SPAN=2) ----------------
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_real = '0, in_imag = '0;
    logic [AW-1:0] tw_addr;
    logic [W-1:0]  tw_real, tw_imag;
    logic          bf_en, bf_valid, out_valid;
    logic [W-1:0]  bf_xa_real, bf_xa_imag, bf_xb_real, bf_xb_imag, bf_w_real, bf_w_imag;
    logic [W-1:0]  bf_ya_real, bf_ya_imag, bf_yb_real, bf_yb_imag, out_real, out_imag;

    fft_sdf_stage_ctrl #(.WIDTH(W), .LOG_N(LOG_N), .LOG_SPAN(LOG_SPAN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
        .tw_addr(tw_addr), .tw_real(tw_real), .tw_imag(tw_imag), .bf_en(bf_en),
        .bf_xa_real(bf_xa_real), .bf_xa_imag(bf_xa_imag), .bf_xb_real(bf_xb_real),
        .bf_xb_imag(bf_xb_imag), .bf_w_real(bf_w_real), .bf_w_imag(bf_w_imag),
        .bf_valid(bf_valid), .bf_ya_real(bf_ya_real), .bf_ya_imag(bf_ya_imag),
        .bf_yb_real(bf_yb_real), .bf_yb_imag(bf_yb_imag), .out_valid(out_valid),
        .out_real(out_real), .out_imag(out_imag));

    // ---------------- instance B (LOG_N=3, LOG_SPAN=0) ----------------
    logic          in_valid_b = 1'b0;
    logic [W-1:0]  in_real_b = '0, in_imag_b = '0;
    logic [1:0]    tw_addr_b;
    logic [W-1:0]  tw_real_b, tw_imag_b;
    logic          bf_en_b, bf_valid_b, out_valid_b;
    logic [W-1:0]  bf_xa_real_b, bf_xa_imag_b, bf_xb_real_b, bf_xb_imag_b, bf_w_real_b, bf_w_imag_b;
    logic [W-1:0]  bf_ya_real_b, bf_ya_imag_b, bf_yb_real_b, bf_yb_imag_b, out_real_b, out_imag_b;

    fft_sdf_stage_ctrl #(.WIDTH(W), .LOG_N(3), .LOG_SPAN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_real(in_real_b), .in_imag(in_imag_b),
        .tw_addr(tw_addr_b), .tw_real(tw_real_b), .tw_imag(tw_imag_b), .bf_en(bf_en_b),
        .bf_xa_real(bf_xa_real_b), .bf_xa_imag(bf_xa_imag_b), .bf_xb_real(bf_xb_real_b),
        .bf_xb_imag(bf_xb_imag_b), .bf_w_real(bf_w_real_b), .bf_w_imag(bf_w_imag_b),
        .bf_valid(bf_valid_b), .bf_ya_real(bf_ya_real_b), .bf_ya_imag(bf_ya_imag_b),
        .bf_yb_real(bf_yb_real_b), .bf_yb_imag(bf_yb_imag_b), .out_valid(out_valid_b),
        .out_real(out_real_b), .out_imag(out_imag_b));

    // ---------------- twiddle ROMs and butterfly models ----------------
    bit rom_flat = 1'b1;

    function automatic logic [2*W-1:0] rom(input bit flat, input int a);
        if (flat) return {W'(256), W'(0)};
        return {W'(256 - 5 * a), W'(3 * a - 40)};
    endfunction

    // Q8 twiddle: ya = a + b*w, yb = a - b*w, wrapped to W bits.
    function automatic logic [4*W-1:0] bfly(input logic [2*W-1:0] a, b, w);
        int ar, ai, br, bi, wr, wi, pr, pi;
        ar = $signed(a[2*W-1:W]); ai = $signed(a[W-1:0]);
        br = $signed(b[2*W-1:W]); bi = $signed(b[W-1:0]);
        wr = $signed(w[2*W-1:W]); wi = $signed(w[W-1:0]);
        pr = (br * wr - bi * wi) >>> 8;
        pi = (br * wi + bi * wr) >>> 8;
        return {W'(ar + pr), W'(ai + pi), W'(ar - pr), W'(ai - pi)};
    endfunction

    function automatic logic [W-1:0] sc(input logic [W-1:0] x);
`ifdef FFT_STAGE_SCALE_EN
        int v;
        v = (int'($signed(x)) + 1) >>> 1;
        if (v > 2 ** (W - 1) - 1) v = 2 ** (W - 1) - 1;
        return W'(v);
`else
        return x;
`endif
    endfunction

    assign {tw_real, tw_imag} = rom(rom_flat, int'(tw_addr));
    assign tw_real_b = W'(256);
    assign tw_imag_b = '0;

    logic [2:0]     pv_a = '0, pv_b = '0;
    logic [4*W-1:0] pd_a [3];
    logic [4*W-1:0] pd_b [3];
    always @(posedge clk) begin
        pv_a    <= {pv_a[1:0], bf_en};
        pd_a[0] <= bfly({bf_xa_real, bf_xa_imag}, {bf_xb_real, bf_xb_imag}, {bf_w_real, bf_w_imag});
        pd_a[1] <= pd_a[0];
        pd_a[2] <= pd_a[1];
        pv_b    <= {pv_b[1:0], bf_en_b};
        pd_b[0] <= bfly({bf_xa_real_b, bf_xa_imag_b}, {bf_xb_real_b, bf_xb_imag_b},
                        {bf_w_real_b, bf_w_imag_b});
        pd_b[1] <= pd_b[0];
        pd_b[2] <= pd_b[1];
    end
    assign bf_valid = pv_a[2];
    assign {bf_ya_real, bf_ya_imag, bf_yb_real, bf_yb_imag} = pd_a[2];
    assign bf_valid_b = pv_b[2];
    assign {bf_ya_real_b, bf_ya_imag_b, bf_yb_real_b, bf_yb_imag_b} = pd_b[2];

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [2*W-1:0] xbuf [HALF];
    logic [2*W-1:0] ybuf [HALF];
    int             mj = 0;
    logic [2*W-1:0] exp_q[$];
    int             exp_cyc_q[$];

    // t is the clock edge at which the DUT accepts sample s.
    task automatic model_accept(input int t, input logic [2*W-1:0] s);
        logic [4*W-1:0] y;
        int i;
        if (mj < HALF) begin
            xbuf[mj] = s;
        end else begin
            i = mj - HALF;
            check("tw_addr", 64'(tw_addr), 64'(i << TW_SHIFT));
            y = bfly(xbuf[i], s, rom(rom_flat, i << TW_SHIFT));
            exp_q.push_back({sc(y[4*W-1:3*W]), sc(y[3*W-1:2*W])});
            exp_cyc_q.push_back(t + 4);
            ybuf[i] = {sc(y[2*W-1:W]), sc(y[W-1:0])};
            if (mj == 2 * HALF - 1) begin
                for (int n = 0; n < HALF; n++) begin
                    exp_q.push_back(ybuf[n]);
                    exp_cyc_q.push_back(t + 5 + n);
                end
            end
        end
        mj = (mj + 1) % (2 * HALF);
    endtask

    logic [2*W-1:0] mon_e;
    int             mon_c;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("out_data", 64'({out_real, out_imag}), 64'(mon_e));
                check("out_cycle", 64'(cyc), 64'(mon_c));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        model_accept(cyc + 1, {re, im});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'(int'($urandom_range(0, 4000)) - 2000);
    endfunction

    task automatic wait_drain();
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    // Two-sample group on the LOG_SPAN=0 instance with exact cycle checks.
    task automatic b_case(input logic [2*W-1:0] s0, input logic [2*W-1:0] s1);
        logic [4*W-1:0] y;
        y = bfly(s0, s1, {W'(256), W'(0)});
        in_valid_b = 1'b1;
        {in_real_b, in_imag_b} = s0;
        idle(1);
        {in_real_b, in_imag_b} = s1;
        check("b_tw_addr", 64'(tw_addr_b), 64'(0));
        idle(1);
        in_valid_b = 1'b0;
        check("b_bf_en", 64'(bf_en_b), 64'(1));
        check("b_bf_xa", 64'({bf_xa_real_b, bf_xa_imag_b}), 64'(s0));
        check("b_bf_xb", 64'({bf_xb_real_b, bf_xb_imag_b}), 64'(s1));
        check("b_bf_w", 64'({bf_w_real_b, bf_w_imag_b}), 64'({W'(256), W'(0)}));
        idle(3);
        check("b_early_out", 64'(out_valid_b), 64'(0));
        idle(1);
        check("b_ya_valid", 64'(out_valid_b), 64'(1));
        check("b_ya", 64'({out_real_b, out_imag_b}), 64'({sc(y[4*W-1:3*W]), sc(y[3*W-1:2*W])}));
        idle(1);
        check("b_yb_valid", 64'(out_valid_b), 64'(1));
        check("b_yb", 64'({out_real_b, out_imag_b}), 64'({sc(y[2*W-1:W]), sc(y[W-1:0])}));
        idle(1);
        check("b_after_out", 64'(out_valid_b), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(3);
        check("rst_bf_en", 64'(bf_en), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_real, out_imag}), 64'(0));
        check("rst_tw_addr", 64'(tw_addr), 64'(0));
        check("rst_bf_ops", 64'({bf_xa_real, bf_xb_imag, bf_w_real}), 64'(0));
        check("rst_b_out_valid", 64'(out_valid_b), 64'(0));
        rst = 1'b0;
        idle(4);

        // LOG_SPAN=0 latency and pass-through/scaling cases
        b_case({W'(256), W'(0)}, {W'(256), W'(0)});
        b_case({W'(3), W'(-3)}, {W'(0), W'(0)});

        // continuous ramp with unity twiddles: ya 64,96,128,160 then yb -64 x4
        for (int j = 0; j < 2 * HALF; j++) send(W'(16 * j), '0);

        // same ramp with a 3-cycle input gap in the issue half
        for (int j = 0; j < 2 * HALF; j++) begin
            send(W'(16 * j), '0);
            if (j == 5) idle(3);
        end
        wait_drain();

        // reset in the middle of a group; stale butterfly results must vanish
        for (int j = 0; j < 6; j++) send(rnd(), rnd());
        rst = 1'b1;
        mj = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        idle(1);
        rst = 1'b0;
        check("midrst_bf_en", 64'(bf_en), 64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        for (int j = 0; j < 2 * HALF; j++) send(rnd(), rnd());
        wait_drain();

        // four back-to-back random groups with a non-trivial twiddle table
        rom_flat = 1'b0;
        repeat (4 * 2 * HALF) send(rnd(), rnd());

        // random groups with random input gaps
        repeat (3 * 2 * HALF) begin
            send(rnd(), rnd());
            idle($urandom_range(0, 2));
        end
        wait_drain();
        idle(10);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
